// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - LSU opcodes, access-size codes, FSM states and request decode helpers
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  function automatic logic valid_pair(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OP_LOAD) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    end else if (op == OP_STORE) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return ok;
  endfunction

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (f3[1:0] == 2'b01) begin
      mis = lo[0];
    end else if (f3 == F3_W) begin
      mis = (lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering: store byte enables/replication, load lane select and extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'b1111;
    wdata     = 32'h0;
    load_data = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end else begin
      case (funct3)
        F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
        F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
        F3_W:    load_data = rdata;
        F3_BU:   load_data = {24'h0, byte_sel};
        F3_HU:   load_data = {16'h0, half_sel};
        default: load_data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: request latch, IDLE/ACCESS/DONE FSM, ack timeout
// Optional: LSU_MISALIGN_TRAP_EN traps misaligned half/word requests without touching memory.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [6:0]  opcode_q, opcode_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] load_q, load_d;
  logic        bus_err_q, bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  logic        is_store;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        start_ok;

  assign is_store = (opcode_q == OP_STORE);
  assign start_ok = start && valid_pair(opcode, funct3);

  lsu_align u_align (
    .is_store   (is_store),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    bus_err_d = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d     = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          addr_d    = addr;
          sdata_d   = store_data;
          opcode_d  = opcode;
          funct3_d  = funct3;
          cnt_d     = '0;
          load_d    = 32'h0;
          bus_err_d = 1'b0;
          state_d   = ST_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_d     = misaligned(funct3, addr[1:0]);
          if (mis_d) state_d = ST_DONE;
`endif
        end
      end
      ST_ACCESS: begin
        // An ack on the expiry cycle still counts as a normal completion.
        if (mem_ack) begin
          load_d  = is_store ? 32'h0 : al_load;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          load_d    = 32'h0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        load_d    = 32'h0;
        bus_err_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d     = 1'b0;
`endif
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'h0;
      sdata_q   <= 32'h0;
      opcode_q  <= 7'h0;
      funct3_q  <= 3'h0;
      cnt_q     <= '0;
      load_q    <= 32'h0;
      bus_err_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      bus_err_q <= bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Memory-side outputs are only live in ACCESS so IDLE/DONE present a quiet bus.
  assign mem_req   = (state_q == ST_ACCESS);
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_we    = mem_req && is_store;
  assign mem_be    = mem_req ? al_be : 4'b0000;
  assign mem_wdata = (mem_req && is_store) ? al_wdata : 32'h0;

  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign load_data = done ? load_q : 32'h0;
  assign bus_err   = done && bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = done && mis_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed vector table plus hand sequences for timeout, reset and ignore cases
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic        bus_err;
  logic        misalign_err;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .load_data    (load_data),
    .done         (done),
    .busy         (busy),
    .bus_err      (bus_err),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_cyc;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk1({tag, "_req"}, mem_req, 1'b0);
    chk1({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_be"}, 32'(mem_be), 32'h0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_load"}, load_data, 32'h0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_buserr"}, bus_err, 1'b0);
    chk1({tag, "_mis"}, misalign_err, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1; opcode = v.op; funct3 = v.f3; addr = v.addr; store_data = v.sdata;
    mem_rdata = 32'h5A5A_5A5A;
    for (int c = 1; c <= v.ack_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; addr = 32'hFFFF_FFFF; store_data = ~v.sdata;
      end
      chk1({t, "_req"}, mem_req, 1'b1);
      chk({t, "_addr"}, mem_addr, v.e_addr);
      chk1({t, "_we"}, mem_we, v.e_we);
      chk({t, "_be"}, 32'(mem_be), 32'(v.e_be));
      if (v.e_we) chk({t, "_wdata"}, mem_wdata, v.e_wdata);
      chk1({t, "_early_done"}, done, 1'b0);
      chk1({t, "_busy"}, busy, 1'b1);
      if (c == v.ack_cyc) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk1({t, "_done"}, done, 1'b1);
    chk({t, "_load"}, load_data, v.e_load);
    chk1({t, "_buserr"}, bus_err, 1'b0);
    chk1({t, "_mis"}, misalign_err, 1'b0);
    chk1({t, "_req_off"}, mem_req, 1'b0);
    @(negedge clk);
    chk1({t, "_done_pulse"}, done, 1'b0);
    chk1({t, "_idle"}, busy, 1'b0);
    n_vec++;
  endtask

  task automatic run_timeout(input logic ack_last);
    string t;
    t = ack_last ? "ackwin" : "timeout";
    @(negedge clk);
    start = 1'b1; opcode = OP_LOAD; funct3 = F3_W; addr = 32'h70;
    @(negedge clk);
    start = 1'b0; mem_rdata = 32'h1111_1111;
    for (int c = 1; c <= 16; c++) begin
      chk1($sformatf("%s_req_c%0d", t, c), mem_req, 1'b1);
      chk1($sformatf("%s_done_c%0d", t, c), done, 1'b0);
      if (ack_last && c == 16) begin
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk1({t, "_req_drop"}, mem_req, 1'b0);
    chk1({t, "_done"}, done, 1'b1);
    chk1({t, "_buserr"}, bus_err, !ack_last);
    chk({t, "_load"}, load_data, ack_last ? 32'h1357_9BDF : 32'h0);
    @(negedge clk);
    chk1({t, "_done_pulse"}, done, 1'b0);
    chk1({t, "_buserr_clr"}, bus_err, 1'b0);
    mem_rdata = 32'h0;
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt.push_back('{OP_STORE, F3_B,  32'h103, 32'h0000_00AB, 32'h0,         2, 32'h100, 1'b1, 4'b1000, 32'hABAB_ABAB, 32'h0});
    vt.push_back('{OP_LOAD,  F3_B,  32'h202, 32'h0,         32'h0080_0000, 1, 32'h200, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80});
    vt.push_back('{OP_LOAD,  F3_BU, 32'h202, 32'h0,         32'h0080_0000, 1, 32'h200, 1'b0, 4'b1111, 32'h0,         32'h0000_0080});
    vt.push_back('{OP_LOAD,  F3_H,  32'h006, 32'h0,         32'h8001_1234, 3, 32'h004, 1'b0, 4'b1111, 32'h0,         32'hFFFF_8001});
    vt.push_back('{OP_LOAD,  F3_HU, 32'h006, 32'h0,         32'h8001_1234, 1, 32'h004, 1'b0, 4'b1111, 32'h0,         32'h0000_8001});
    vt.push_back('{OP_LOAD,  F3_W,  32'h010, 32'h0,         32'hDEAD_BEEF, 4, 32'h010, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF});
    vt.push_back('{OP_STORE, F3_H,  32'h012, 32'h1234_ABCD, 32'h0,         1, 32'h010, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0});
    vt.push_back('{OP_STORE, F3_H,  32'h020, 32'h0000_5678, 32'hFFFF_FFFF, 2, 32'h020, 1'b1, 4'b0011, 32'h5678_5678, 32'h0});
    vt.push_back('{OP_STORE, F3_W,  32'h030, 32'hCAFE_F00D, 32'h0,         5, 32'h030, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0});
    vt.push_back('{OP_STORE, F3_B,  32'h041, 32'h1234_5677, 32'h0,         1, 32'h040, 1'b1, 4'b0010, 32'h7777_7777, 32'h0});
    vt.push_back('{OP_LOAD,  F3_B,  32'h051, 32'h0,         32'h1234_7F56, 2, 32'h050, 1'b0, 4'b1111, 32'h0,         32'h0000_007F});
    vt.push_back('{OP_LOAD,  F3_H,  32'h060, 32'h0,         32'h0000_7FFF, 1, 32'h060, 1'b0, 4'b1111, 32'h0,         32'h0000_7FFF});
    vt.push_back('{OP_LOAD,  F3_BU, 32'h203, 32'h0,         32'h9A00_0000, 1, 32'h200, 1'b0, 4'b1111, 32'h0,         32'h0000_009A});
`ifndef LSU_MISALIGN_TRAP_EN
    vt.push_back('{OP_STORE, F3_W,  32'h102, 32'h0102_0304, 32'h0,         1, 32'h100, 1'b1, 4'b1111, 32'h0102_0304, 32'h0});
`endif

    reset = 1'b1; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; addr = 32'h0;
    store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    foreach (vt[i]) run_vec(vt[i], i);

    run_timeout(1'b0);
    run_timeout(1'b1);

    // Invalid opcode/funct3 pairs and an idle ack must not start anything.
    @(negedge clk);
    start = 1'b1; opcode = OP_LOAD; funct3 = 3'b011; addr = 32'h300;
    @(negedge clk);
    chk1("bad_f3_busy", busy, 1'b0);
    opcode = OP_STORE; funct3 = F3_BU;
    @(negedge clk);
    chk1("bad_st_busy", busy, 1'b0);
    opcode = 7'b0010011; funct3 = F3_B;
    @(negedge clk);
    chk1("bad_op_busy", busy, 1'b0);
    start = 1'b0; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_quiet("idle_ack");
    n_vec++;

    // start held high while busy is ignored, including in DONE.
    start = 1'b1; opcode = OP_STORE; funct3 = F3_W; addr = 32'h80; store_data = 32'h1;
    @(negedge clk);
    opcode = OP_LOAD; addr = 32'h900;
    chk("busy_ign_addr1", mem_addr, 32'h80);
    @(negedge clk);
    chk("busy_ign_addr2", mem_addr, 32'h80);
    chk1("busy_ign_we", mem_we, 1'b1);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk1("busy_ign_done", done, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk1("busy_ign_idle", busy, 1'b0);
    chk1("busy_ign_req", mem_req, 1'b0);
    n_vec++;

    // Reset in the 3rd ACCESS cycle, ack one cycle later.
    @(negedge clk);
    start = 1'b1; opcode = OP_STORE; funct3 = F3_W; addr = 32'h44; store_data = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_pre_req", mem_req, 1'b1);
    chk("rst_pre_wdata", mem_wdata, 32'hFFFF_FFFF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    check_quiet("rst_c4");
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check_quiet("rst_c5");
    @(negedge clk);
    check_quiet("rst_c6");
    n_vec++;

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    start = 1'b1; opcode = OP_STORE; funct3 = F3_W; addr = 32'h102; store_data = 32'h0102_0304;
    @(negedge clk);
    start = 1'b0;
    chk1("trap_sw_req", mem_req, 1'b0);
    chk1("trap_sw_done", done, 1'b1);
    chk1("trap_sw_mis", misalign_err, 1'b1);
    chk1("trap_sw_buserr", bus_err, 1'b0);
    @(negedge clk);
    chk1("trap_sw_done_pulse", done, 1'b0);
    chk1("trap_sw_mis_clr", misalign_err, 1'b0);
    start = 1'b1; opcode = OP_LOAD; funct3 = F3_HU; addr = 32'h205;
    @(negedge clk);
    start = 1'b0;
    chk1("trap_lh_req", mem_req, 1'b0);
    chk1("trap_lh_mis", misalign_err, 1'b1);
    @(negedge clk);
    chk1("trap_lh_idle", busy, 1'b0);
    n_vec += 2;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
